// File: rtl/cache_pkg.sv
// Shared definitions for the cache refill path: FSM encodings and
// helper sizing for the way-fill demux.
package cache_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_FILL = 1'b1
    } fill_state_t;

    // Word-index width; a one-word line still carries a 1-bit index.
    function automatic int idx_width(input int words);
        return (words <= 1) ? 1 : $clog2(words);
    endfunction

    localparam int SEL_WIDTH_DFLT = 3;
    localparam int WORDS_DFLT     = 4;
    localparam int N              = 1 << SEL_WIDTH_DFLT;
    localparam int IDXW           = idx_width(WORDS_DFLT);

endpackage

// File: rtl/dec_onehot.sv
// Binary way select to one-hot decoder (purely combinational).
module dec_onehot #(
    parameter int SEL_WIDTH = 3
) (
    input  logic [SEL_WIDTH-1:0]      sel,
    output logic [(1<<SEL_WIDTH)-1:0] onehot
);

    // Exactly one bit set for every select value.
    always_comb begin
        onehot      = '0;
        onehot[sel] = 1'b1;
    end

endmodule

// File: rtl/way_fill_demux.sv
// Way-fill demux: takes refill words over valid/ready, steers each into
// the latched way as a registered one-hot write strobe with word index
// and data, and pulses done alongside the last word of the line.
//
// state   | meaning
// --------+-----------------------------------------------
// ST_IDLE | waiting for start; in_ready low, beats ignored
// ST_FILL | accepting words for the latched way
module way_fill_demux
    import cache_pkg::*;
#(
    parameter int SEL_WIDTH = 3,
    parameter int w         = 8,
    parameter int WORDS     = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           start,
    input  logic [SEL_WIDTH-1:0]           start_way,
    output logic                           busy,
    input  logic                           in_valid,
    input  logic [w-1:0]                   in_data,
    output logic                           in_ready,
    output logic [(1<<SEL_WIDTH)-1:0]      way_we,
    output logic [idx_width(WORDS)-1:0]    way_word,
    output logic [w-1:0]                   way_wdata,
    output logic                           done
);

    localparam int N_WAYS = 1 << SEL_WIDTH;
    localparam int IDX_W  = idx_width(WORDS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

    fill_state_t          state_q, state_d;
    logic [SEL_WIDTH-1:0] way_q, way_d;
    logic [IDX_W-1:0]     cnt_q, cnt_d;
    logic [N_WAYS-1:0]    way_onehot;
    logic [N_WAYS-1:0]    we_d;
    logic                 accept;
    logic                 last_beat;

    assign in_ready  = (state_q == ST_FILL);
    assign busy      = (state_q == ST_FILL);
    assign accept    = in_valid && (state_q == ST_FILL);
    assign last_beat = (cnt_q == LAST_IDX);

    dec_onehot #(.SEL_WIDTH(SEL_WIDTH)) u_dec (
        .sel    (way_q),
        .onehot (way_onehot)
    );

    // Only an accepted beat may raise a write enable.
    always_comb begin
        we_d = accept ? way_onehot : '0;
    end

    // Next-state, way latch and word counter.
    always_comb begin
        state_d = state_q;
        way_d   = way_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_FILL;
                    way_d   = start_way;
                    cnt_d   = '0;
                end
            end
            ST_FILL: begin
                if (accept) begin
                    if (last_beat) begin
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d = cnt_q + IDX_W'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM, way and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            way_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            way_q   <= way_d;
            cnt_q   <= cnt_d;
        end
    end

    // Write-side output registers; index and data hold between beats.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            way_we    <= '0;
            way_word  <= '0;
            way_wdata <= '0;
            done      <= 1'b0;
        end else begin
            way_we <= we_d;
            done   <= accept && last_beat;
            if (accept) begin
                way_word  <= cnt_q;
                way_wdata <= in_data;
            end
        end
    end

endmodule

// File: tb/tb_way_fill_demux.sv
// Directed bench for way_fill_demux (8 ways, 8-bit words, 4-word lines).
module tb_way_fill_demux;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [2:0] start_way;
    logic       busy;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic [7:0] way_we;
    logic [1:0] way_word;
    logic [7:0] way_wdata;
    logic       done;

    int pass_cnt  = 0;
    int total_cnt = 0;

    // Tracked hold values of way_word / way_wdata
    logic [1:0] exp_word;
    logic [7:0] exp_data;

    // {busy, in_ready, done, way_we, way_word, way_wdata}
    logic [20:0] obs;
    logic [20:0] exp_v;

    way_fill_demux #(.SEL_WIDTH(3), .w(8), .WORDS(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .start_way (start_way),
        .busy      (busy),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .way_we    (way_we),
        .way_word  (way_word),
        .way_wdata (way_wdata),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; start_way = '0; in_valid = 1'b0; in_data = '0;
        exp_word = '0; exp_data = '0;
        step(); step();
        total_cnt++;
        obs = {busy, in_ready, done, way_we, way_word, way_wdata};
        if (obs !== 21'h0) $display("FAIL reset_held obs=%h exp=%h", obs, 21'h0);
        else pass_cnt++;
        rst_n = 1'b1;
        step();
        total_cnt++;
        obs = {busy, in_ready, done, way_we, way_word, way_wdata};
        if (obs !== 21'h0) $display("FAIL reset_release obs=%h exp=%h", obs, 21'h0);
        else pass_cnt++;
        // beat offered while idle is ignored
        in_valid = 1'b1; in_data = 8'hAA;
        for (int c = 0; c < 2; c++) begin
            step();
            total_cnt++;
            obs = {busy, in_ready, done, way_we, way_word, way_wdata};
            if (obs !== 21'h0) $display("FAIL idle_valid_ignored c=%0d obs=%h exp=%h", c, obs, 21'h0);
            else pass_cnt++;
        end
        in_valid = 1'b0;
    endtask

    task automatic test_single_fill();
        start = 1'b1; start_way = 3'd5;
        step();
        start = 1'b0;
        total_cnt++;
        obs = {busy, in_ready, done, way_we, way_word, way_wdata};
        exp_v = {1'b1, 1'b1, 1'b0, 8'h00, exp_word, exp_data};
        if (obs !== exp_v) $display("FAIL fill_start obs=%h exp=%h", obs, exp_v);
        else pass_cnt++;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_data = 8'h05 + 8'(i * 16);
            step();
            exp_word = 2'(i); exp_data = 8'h05 + 8'(i * 16);
            total_cnt++;
            obs = {busy, in_ready, done, way_we, way_word, way_wdata};
            exp_v = {(i != 3), (i != 3), (i == 3), 8'h20, exp_word, exp_data};
            if (obs !== exp_v) $display("FAIL fill_beat i=%0d obs=%h exp=%h", i, obs, exp_v);
            else pass_cnt++;
        end
        in_valid = 1'b0;
        step();
        total_cnt++;
        obs = {busy, in_ready, done, way_we, way_word, way_wdata};
        exp_v = {1'b0, 1'b0, 1'b0, 8'h00, exp_word, exp_data};
        if (obs !== exp_v) $display("FAIL fill_after obs=%h exp=%h", obs, exp_v);
        else pass_cnt++;
    endtask

    task automatic test_gaps();
        int acc;
        start = 1'b1; start_way = 3'd2;
        step();
        start = 1'b0;
        acc = 0;
        for (int c = 0; c < 8; c++) begin
            in_valid = (c % 2 == 0);
            in_data  = 8'h40 + 8'(c);
            step();
            if (c % 2 == 0) begin
                exp_word = 2'(acc); exp_data = 8'h40 + 8'(c);
                acc++;
                exp_v = {(acc != 4), (acc != 4), (acc == 4), 8'h04, exp_word, exp_data};
            end else begin
                exp_v = {(acc != 4), (acc != 4), 1'b0, 8'h00, exp_word, exp_data};
            end
            total_cnt++;
            obs = {busy, in_ready, done, way_we, way_word, way_wdata};
            if (obs !== exp_v) $display("FAIL gap_cycle c=%0d obs=%h exp=%h", c, obs, exp_v);
            else pass_cnt++;
        end
        in_valid = 1'b0;
    endtask

    task automatic test_start_ignored();
        start = 1'b1; start_way = 3'd1;
        step();
        for (int i = 0; i < 4; i++) begin
            start     = (i == 1);
            start_way = (i == 1) ? 3'd7 : 3'd1;
            in_valid  = 1'b1; in_data = 8'hC0 + 8'(i);
            step();
            exp_word = 2'(i); exp_data = 8'hC0 + 8'(i);
            total_cnt++;
            obs = {busy, in_ready, done, way_we, way_word, way_wdata};
            exp_v = {(i != 3), (i != 3), (i == 3), 8'h02, exp_word, exp_data};
            if (obs !== exp_v) $display("FAIL busy_start_beat i=%0d obs=%h exp=%h", i, obs, exp_v);
            else pass_cnt++;
        end
        start = 1'b0; in_valid = 1'b0;
        step();
    endtask

    task automatic test_reset_mid_fill();
        start = 1'b1; start_way = 3'd3;
        step();
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1; in_data = 8'h70 + 8'(i);
            step();
            exp_word = 2'(i); exp_data = 8'h70 + 8'(i);
            total_cnt++;
            obs = {busy, in_ready, done, way_we, way_word, way_wdata};
            exp_v = {1'b1, 1'b1, 1'b0, 8'h08, exp_word, exp_data};
            if (obs !== exp_v) $display("FAIL partial_beat i=%0d obs=%h exp=%h", i, obs, exp_v);
            else pass_cnt++;
        end
        in_data = 8'h72;
        #2 rst_n = 1'b0;
        #1;
        exp_word = '0; exp_data = '0;
        total_cnt++;
        obs = {busy, in_ready, done, way_we, way_word, way_wdata};
        if (obs !== 21'h0) $display("FAIL async_reset obs=%h exp=%h", obs, 21'h0);
        else pass_cnt++;
        step();
        rst_n = 1'b1;
        step();
        total_cnt++;
        obs = {busy, in_ready, done, way_we, way_word, way_wdata};
        if (obs !== 21'h0) $display("FAIL post_reset_idle obs=%h exp=%h", obs, 21'h0);
        else pass_cnt++;
        in_valid = 1'b0;
        start = 1'b1; start_way = 3'd0;
        step();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_data = 8'h90 + 8'(i);
            step();
            exp_word = 2'(i); exp_data = 8'h90 + 8'(i);
            total_cnt++;
            obs = {busy, in_ready, done, way_we, way_word, way_wdata};
            exp_v = {(i != 3), (i != 3), (i == 3), 8'h01, exp_word, exp_data};
            if (obs !== exp_v) $display("FAIL refill_beat i=%0d obs=%h exp=%h", i, obs, exp_v);
            else pass_cnt++;
        end
        in_valid = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [7:0] onehot;
        for (int k = 0; k < 8; k++) begin
            start = 1'b1; start_way = 3'(k); in_valid = 1'b0;
            step();
            start = 1'b0;
            total_cnt++;
            obs = {busy, in_ready, done, way_we, way_word, way_wdata};
            exp_v = {1'b1, 1'b1, 1'b0, 8'h00, exp_word, exp_data};
            if (obs !== exp_v) $display("FAIL b2b_start k=%0d obs=%h exp=%h", k, obs, exp_v);
            else pass_cnt++;
            onehot = 8'h01 << k;
            for (int i = 0; i < 4; i++) begin
                in_valid = 1'b1; in_data = 8'(k * 16) + 8'h05;
                step();
                exp_word = 2'(i); exp_data = 8'(k * 16) + 8'h05;
                total_cnt++;
                obs = {busy, in_ready, done, way_we, way_word, way_wdata};
                exp_v = {(i != 3), (i != 3), (i == 3), onehot, exp_word, exp_data};
                if (obs !== exp_v) $display("FAIL b2b_beat k=%0d i=%0d obs=%h exp=%h", k, i, obs, exp_v);
                else pass_cnt++;
            end
        end
        in_valid = 1'b0;
        step();
        total_cnt++;
        obs = {busy, in_ready, done, way_we, way_word, way_wdata};
        exp_v = {1'b0, 1'b0, 1'b0, 8'h00, exp_word, exp_data};
        if (obs !== exp_v) $display("FAIL b2b_end obs=%h exp=%h", obs, exp_v);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_single_fill();
        test_gaps();
        test_start_ignored();
        test_reset_mid_fill();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
